// File: rtl/rbm_result_writer.sv
// Avalon-MM controlled result writer: latches a destination base/length, kicks the
// memory-writer master, then streams sink words into its user FIFO until the job completes.
module rbm_result_writer #(
    parameter int DATAWIDTH     = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               avs_s0_address,
    input  logic                     avs_s0_read,
    input  logic                     avs_s0_write,
    input  logic [ADDRESS_WIDTH-1:0] avs_s0_writedata,
    output logic [ADDRESS_WIDTH-1:0] avs_s0_readdata,
    output logic                     avs_s0_readdatavalid,
    output logic                     coe_control_fixed_location,
    output logic [ADDRESS_WIDTH-1:0] coe_control_write_base,
    output logic [ADDRESS_WIDTH-1:0] coe_control_write_length,
    output logic                     coe_control_go,
    input  logic                     coe_control_done,
    output logic                     coe_user_write_buffer,
    output logic [DATAWIDTH-1:0]     coe_user_buffer_data,
    input  logic                     coe_user_buffer_full,
    input  logic [DATAWIDTH-1:0]     snk_data,
    input  logic                     snk_valid,
    output logic                     snk_ready
);

    localparam int unsigned SHIFT = $clog2(DATAWIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GO,
        S_STREAM,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH-1:0] length_q;
    logic [ADDRESS_WIDTH-1:0] remaining_q;
    logic [ADDRESS_WIDTH-1:0] count_q;
    logic                     done_flag_q;
    logic                     go_q;
    logic [ADDRESS_WIDTH-1:0] readdata_q;
    logic                     rdvalid_q;

    logic [ADDRESS_WIDTH-1:0] readdata_d;
    logic [ADDRESS_WIDTH-1:0] words_d;
    logic                     start_req;
    logic                     busy;
    logic                     push;

    assign words_d   = length_q >> SHIFT;
    assign busy      = (state_q != S_IDLE);
    assign start_req = avs_s0_write && (avs_s0_address == 2'd2) && avs_s0_writedata[0];

    // Gated by reset so a mid-job reset cannot leak a push during the reset cycle.
    assign snk_ready = reset && (state_q == S_STREAM) && !coe_user_buffer_full
                       && (remaining_q != '0);
    assign push      = snk_valid && snk_ready;

    assign coe_user_write_buffer      = push;
    assign coe_user_buffer_data       = snk_data;
    assign coe_control_fixed_location = 1'b0;
    assign coe_control_write_base     = base_q;
    assign coe_control_write_length   = length_q;
    assign coe_control_go             = go_q;
    assign avs_s0_readdata            = readdata_q;
    assign avs_s0_readdatavalid       = rdvalid_q;

    always_comb begin
        readdata_d = '0;
        case (avs_s0_address)
            2'd0:    readdata_d = base_q;
            2'd1:    readdata_d = length_q;
            2'd2:    readdata_d[1:0] = {done_flag_q, busy};
            default: readdata_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            length_q    <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            done_flag_q <= 1'b0;
            go_q        <= 1'b0;
            readdata_q  <= '0;
            rdvalid_q   <= 1'b0;
        end else begin
            go_q      <= 1'b0;
            rdvalid_q <= avs_s0_read;
            if (avs_s0_read) begin
                readdata_q <= readdata_d;
            end
            if (push) begin
                remaining_q <= remaining_q - ADDRESS_WIDTH'(1);
                count_q     <= count_q + ADDRESS_WIDTH'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (avs_s0_write && (avs_s0_address == 2'd0)) begin
                        base_q <= avs_s0_writedata;
                    end
                    if (avs_s0_write && (avs_s0_address == 2'd1)) begin
                        length_q <= avs_s0_writedata;
                    end
                    if (start_req) begin
                        done_flag_q <= 1'b0;
                        count_q     <= '0;
                        remaining_q <= words_d;
                        if (words_d == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_GO;
                            go_q    <= 1'b1;
                        end
                    end
                end
                S_GO: begin
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    if (push && (remaining_q == ADDRESS_WIDTH'(1))) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (coe_control_done) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_flag_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rbm_result_writer.sv
// Scoreboard bench for rbm_result_writer: stimulus queues expected pushes and read data,
// a negedge monitor pops and compares whenever the DUT pushes or returns read data.
module tb_rbm_result_writer;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    avs_s0_address = '0;
    logic          avs_s0_read = 1'b0;
    logic          avs_s0_write = 1'b0;
    logic [AW-1:0] avs_s0_writedata = '0;
    logic [AW-1:0] avs_s0_readdata;
    logic          avs_s0_readdatavalid;
    logic          coe_control_fixed_location;
    logic [AW-1:0] coe_control_write_base;
    logic [AW-1:0] coe_control_write_length;
    logic          coe_control_go;
    logic          coe_control_done = 1'b0;
    logic          coe_user_write_buffer;
    logic [DW-1:0] coe_user_buffer_data;
    logic          coe_user_buffer_full = 1'b0;
    logic [DW-1:0] snk_data = '0;
    logic          snk_valid = 1'b0;
    logic          snk_ready;

    int n_vec  = 0;
    int n_err  = 0;
    int go_cnt = 0;
    int g0;

    logic [DW-1:0] exp_push[$];
    logic [AW-1:0] exp_rd[$];

    always #5 clk = ~clk;

    rbm_result_writer #(
        .DATAWIDTH    (DW),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .avs_s0_address            (avs_s0_address),
        .avs_s0_read               (avs_s0_read),
        .avs_s0_write              (avs_s0_write),
        .avs_s0_writedata          (avs_s0_writedata),
        .avs_s0_readdata           (avs_s0_readdata),
        .avs_s0_readdatavalid      (avs_s0_readdatavalid),
        .coe_control_fixed_location(coe_control_fixed_location),
        .coe_control_write_base    (coe_control_write_base),
        .coe_control_write_length  (coe_control_write_length),
        .coe_control_go            (coe_control_go),
        .coe_control_done          (coe_control_done),
        .coe_user_write_buffer     (coe_user_write_buffer),
        .coe_user_buffer_data      (coe_user_buffer_data),
        .coe_user_buffer_full      (coe_user_buffer_full),
        .snk_data                  (snk_data),
        .snk_valid                 (snk_valid),
        .snk_ready                 (snk_ready)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: go pulses, pushes and read responses.
    always @(negedge clk) begin
        if (coe_control_go === 1'b1) go_cnt++;
        if (coe_user_write_buffer === 1'b1) begin
            if (exp_push.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_push: got data 0x%0h, expected no push", coe_user_buffer_data);
            end else begin
                chk("push_data", coe_user_buffer_data, exp_push.pop_front());
                chk("push_while_full", coe_user_buffer_full, 1'b0);
                chk("push_without_valid", snk_valid, 1'b1);
            end
        end
        if (avs_s0_readdatavalid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_readdatavalid: got data 0x%0h, expected none", avs_s0_readdata);
            end else begin
                chk("read_data", avs_s0_readdata, exp_rd.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [AW-1:0] d);
        avs_s0_write = 1'b1;
        avs_s0_address = a;
        avs_s0_writedata = d;
        tick();
        avs_s0_write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [AW-1:0] e);
        avs_s0_read = 1'b1;
        avs_s0_address = a;
        exp_rd.push_back(e);
        tick();
        avs_s0_read = 1'b0;
    endtask

    // Source feeding n words starting at 'first'; optional FIFO-full toggling and early done.
    task automatic stream(input int n, input logic [DW-1:0] first, input bit bp, input int early_done);
        int i = 0;
        int cyc = 0;
        for (int k = 0; k < n; k++) exp_push.push_back(first + DW'(k));
        while (i < n && cyc < 300) begin
            snk_valid = 1'b1;
            snk_data = first + DW'(i);
            coe_user_buffer_full = bp && cyc[0];
            coe_control_done = (cyc == early_done);
            @(negedge clk);
            if (snk_valid && snk_ready) i++;
            tick();
            cyc++;
        end
        snk_valid = 1'b0;
        snk_data = '0;
        coe_user_buffer_full = 1'b0;
        coe_control_done = 1'b0;
        chk("stream_words_within_budget", i, n);
    endtask

    task automatic finish_job(input logic [AW-1:0] words);
        coe_control_done = 1'b1;
        tick();
        coe_control_done = 1'b0;
        tick();
        rd(2'd2, 32'h2);
        rd(2'd3, words);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_readdata", avs_s0_readdata, 0);
        chk("rst_readdatavalid", avs_s0_readdatavalid, 0);
        chk("rst_write_base", coe_control_write_base, 0);
        chk("rst_write_length", coe_control_write_length, 0);
        chk("rst_go", coe_control_go, 0);
        chk("rst_write_buffer", coe_user_write_buffer, 0);
        chk("rst_snk_ready", snk_ready, 0);
        chk("rst_fixed_location", coe_control_fixed_location, 0);
        reset = 1'b1;
        tick();
        rd(2'd2, 32'h0);
        rd(2'd3, 32'h0);

        // Single 8-word job, data 1..8
        wr(2'd0, 32'h1000);
        wr(2'd1, 32'd32);
        g0 = go_cnt;
        wr(2'd2, 32'h1);
        chk("go_timing", coe_control_go, 1);
        tick();
        chk("go_one_cycle", coe_control_go, 0);
        stream(8, 32'd1, 1'b0, -1);
        finish_job(32'd8);
        chk("job1_go_pulses", go_cnt - g0, 1);
        rd(2'd0, 32'h1000);
        rd(2'd1, 32'd32);
        chk("job1_base_out", coe_control_write_base, 32'h1000);

        // 16 words under toggling backpressure; early done must be ignored
        wr(2'd1, 32'd64);
        g0 = go_cnt;
        wr(2'd2, 32'h1);
        tick();
        stream(16, 32'h100, 1'b1, 3);
        rd(2'd2, 32'h1);
        finish_job(32'd16);
        chk("bp_go_pulses", go_cnt - g0, 1);

        // Busy protection: base/length/start writes dropped outside IDLE
        wr(2'd1, 32'd32);
        g0 = go_cnt;
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h2000);
        wr(2'd2, 32'h1);
        wr(2'd1, 32'h40);
        rd(2'd0, 32'h1000);
        rd(2'd1, 32'd32);
        stream(8, 32'h5500_0000, 1'b0, -1);
        finish_job(32'd8);
        chk("busy_go_pulses", go_cnt - g0, 1);
        chk("busy_base_out", coe_control_write_base, 32'h1000);

        // Zero length: straight to done, no go
        wr(2'd1, 32'd0);
        g0 = go_cnt;
        wr(2'd2, 32'h1);
        chk("zero_no_go", coe_control_go, 0);
        tick();
        rd(2'd2, 32'h2);
        rd(2'd3, 32'h0);
        chk("zero_go_pulses", go_cnt - g0, 0);

        // Unaligned length 10 -> 2 words
        wr(2'd1, 32'd10);
        wr(2'd2, 32'h1);
        tick();
        stream(2, 32'hA0, 1'b0, -1);
        finish_job(32'd2);

        // Mid-job reset after 3 of 8 pushes
        wr(2'd1, 32'd32);
        wr(2'd2, 32'h1);
        tick();
        stream(3, 32'h77, 1'b0, -1);
        g0 = go_cnt;
        snk_valid = 1'b1;
        snk_data = 32'hDEAD_BEEF;
        reset = 1'b0;
        tick();
        chk("midrst_go", coe_control_go, 0);
        chk("midrst_snk_ready", snk_ready, 0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        snk_valid = 1'b0;
        chk("midrst_go_pulses", go_cnt - g0, 0);
        chk("midrst_base_out", coe_control_write_base, 0);
        rd(2'd2, 32'h0);
        rd(2'd3, 32'h0);

        repeat (3) tick();
        chk("push_queue_drained", exp_push.size(), 0);
        chk("read_queue_drained", exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rbm_result_writer.md
# rbm_result_writer

Write-side counterpart of the RBM memory-reader front end: an Avalon-MM slave takes a destination base address and byte length, then the block commands a memory-writer master and streams result words from an upstream sink port into the writer's user FIFO. It sits between the RBM compute pipeline and the DDR2 write master. Software gets completion status and a written-word count through the same slave.

## Interface
- DATAWIDTH, 32, width of the result word and the writer FIFO data.
- ADDRESS_WIDTH, 32, width of the address, length and slave data.
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-low reset (0 = reset). One clock; reset is synchronous and active-low.
- avs_s0_address  in  2  0: base, 1: length (bytes), 2: control/status, 3: word count.
- avs_s0_read, avs_s0_write  in  1  slave strobes.
- avs_s0_writedata  in  ADDRESS_WIDTH  slave write data.
- avs_s0_readdata  out  ADDRESS_WIDTH  registered read data.
- avs_s0_readdatavalid  out  1  one-cycle pulse, one cycle after avs_s0_read.
- coe_control_fixed_location  out  1  tied 0.
- coe_control_write_base  out  ADDRESS_WIDTH  latched base register.
- coe_control_write_length  out  ADDRESS_WIDTH  latched length register.
- coe_control_go  out  1  one-cycle start pulse to the writer.
- coe_control_done  in  1  writer finished all bursts.
- coe_user_write_buffer  out  1  push strobe into the writer FIFO.
- coe_user_buffer_data  out  DATAWIDTH  word pushed.
- coe_user_buffer_full  in  1  writer FIFO full.
- snk_data  in  DATAWIDTH  result word from the pipeline.
- snk_valid  in  1  snk_data valid.
- snk_ready  out  1  block accepts snk_data this cycle.

## Operation
- Registers: base and length are written only in IDLE. Writes in other states are dropped.
- Control write (address 2, writedata bit0 = 1) in IDLE starts a job. Any other control write, or a start outside IDLE, is ignored. A start also clears done_flag and the word count.
- Words to transfer = length >> log2(DATAWIDTH/8). Low length bits are ignored.
- FSM states:
  - IDLE: waits for start. If words == 0, go straight to DONE with no go pulse. Otherwise go to GO.
  - GO: coe_control_go = 1 for exactly one cycle, then STREAM.
  - STREAM: snk_ready = !coe_user_buffer_full && remaining != 0.
    - A transfer occurs when snk_valid && snk_ready. That cycle, coe_user_write_buffer = 1, coe_user_buffer_data = snk_data (combinational pass-through), remaining decrements and count increments.
    - When remaining reaches 0, go to WAIT_DONE.
  - WAIT_DONE: snk_ready = 0. Stays until coe_control_done = 1, then DONE.
  - DONE: sets done_flag, then returns to IDLE.
- Reads: address 0 = base, 1 = length, 2 = {zeros, done_flag, busy}, 3 = count (zero-extended). busy = state != IDLE.
- Reads in the same cycle as a write return the pre-write value.

## Timing
- Reset values: readdata 0, readdatavalid 0, write_base 0, write_length 0, go 0, write_buffer 0, snk_ready 0, done_flag 0, count 0, state IDLE.
- Start write at cycle N: go is high at N+1. First possible push is N+2.
- Push throughput: 1 word/cycle while the FIFO is not full and the source is valid. Full deasserts snk_ready in the same cycle, so no push ever occurs while full.
- coe_control_done seen in cycle M: busy reads 0 and done_flag reads 1 from cycle M+2.
- A done arriving early (in STREAM) is ignored. Only done in WAIT_DONE completes the job.
- Reset asserted mid-job: within one cycle the block is back in IDLE with all outputs at reset values. No further push or go is issued.

## Test plan
- Reset values: hold reset = 0 for 3 cycles -> every output at its reset value, then a status read returns 0.
- Single job: base = 0x1000, length = 32 (8 words), start, snk_valid held 1 with data 1..8 -> one go pulse, exactly 8 pushes of 1..8, done at writer -> status 0x2, count 8.
- Backpressure: full toggles every other cycle during a 16-word job -> no push while full, 16 words delivered in order, count 16.
- Zero and unaligned length: length 0 -> no go, status 0x2 immediately. Length 10 -> 2 words pushed.
- Busy protection: rewrite base to 0x2000 and re-start during STREAM -> base still reads 0x1000, no second go pulse.
- Mid-job reset: assert reset after 3 of 8 pushes -> go 0, no further pushes, status 0, count 0.
